// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_arb_mux slice.
// Holds the arbitration mode, FSM state encoding and modulo index wrap.
package stream_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Wrap at n-1 -> 0 so non-power-of-2 channel counts never index past the last channel.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from a pointer, or fixed lowest-index priority.
// Latency 0; no backpressure of its own, the caller gates the grant with its load enable.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_INPUT = 8,
    parameter int ARB_MODE  = 0,
    parameter int IDXW      = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input  logic [NUM_INPUT-1:0] i_req,
    input  logic [IDXW-1:0]      i_ptr,
    output logic [NUM_INPUT-1:0] o_grant,
    output logic [IDXW-1:0]      o_idx,
    output logic                 o_any
);

    logic [IDXW:0] w_base;
    logic [IDXW:0] w_c;

    // Scan from the highest offset down so the closest requester after the base wins.
    always_comb begin
        w_base  = (ARB_MODE == int'(ARB_FIXED)) ? '0 : {1'b0, i_ptr};
        w_c     = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        for (int j = NUM_INPUT - 1; j >= 0; j--) begin
            w_c = w_base + (IDXW+1)'(j);
            if (w_c >= (IDXW+1)'(NUM_INPUT)) begin
                w_c = w_c - (IDXW+1)'(NUM_INPUT);
            end
            if (i_req[w_c[IDXW-1:0]]) begin
                o_idx = w_c[IDXW-1:0];
                o_any = 1'b1;
            end
        end
        for (int k = 0; k < NUM_INPUT; k++) begin
            o_grant[k] = o_any && (o_idx == IDXW'(k));
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N-to-1 stream mux with internal RR/fixed arbitration and optional packet lock; 1-cycle registered output.
// Backpressure: ready is granted only when the output register is empty or being drained this cycle.
module stream_arb_mux
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int NUM_INPUT          = 8,
    parameter int ARB_MODE           = 0,
    parameter int LOCK_ON_LAST       = 1,
    parameter int NUM_INPUT_BITWIDTH = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_WIDTH-1:0]         i_data [NUM_INPUT],
    input  logic [NUM_INPUT-1:0]          i_valid,
    input  logic [NUM_INPUT-1:0]          i_last,
    output logic [NUM_INPUT-1:0]          o_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_last,
    output logic [NUM_INPUT_BITWIDTH-1:0] o_sel,
    output logic                          o_valid,
    input  logic                          i_ready
);

    localparam int IDXW = NUM_INPUT_BITWIDTH;

    arb_state_e            r_state;
    logic [IDXW-1:0]       r_lock_idx;
    logic [IDXW-1:0]       r_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [IDXW-1:0]       r_sel;
    logic                  r_valid;

    logic                  w_load;
    logic [NUM_INPUT-1:0]  w_req;
    logic [NUM_INPUT-1:0]  w_grant;
    logic [IDXW-1:0]       w_idx;
    logic                  w_any;
    logic                  w_xfer;
    logic                  w_idx_last;

    assign w_load = !r_valid || i_ready;

    // While locked, mask every request except the locked channel so a gap stalls instead of switching.
    always_comb begin
        w_req = '0;
        for (int k = 0; k < NUM_INPUT; k++) begin
            w_req[k] = i_valid[k] && (r_state == ST_ARB || r_lock_idx == IDXW'(k));
        end
    end

    rr_arbiter #(
        .NUM_INPUT (NUM_INPUT),
        .ARB_MODE  (ARB_MODE),
        .IDXW      (IDXW)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        o_ready = '0;
        if (!i_rst && w_load) begin
            o_ready = w_grant;
        end
    end

    assign w_xfer     = !i_rst && w_load && w_any;
    assign w_idx_last = i_last[w_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_ARB;
            r_lock_idx <= '0;
            r_ptr      <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_data  <= i_data[w_idx];
                r_last  <= w_idx_last;
                r_sel   <= w_idx;
                r_valid <= 1'b1;
                if (LOCK_ON_LAST != 0) begin
                    if (w_idx_last) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_state    <= ST_LOCKED;
                        r_lock_idx <= w_idx;
                    end
                end
                if (LOCK_ON_LAST == 0 || w_idx_last) begin
                    r_ptr <= IDXW'(next_idx(int'(w_idx), NUM_INPUT));
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_sel   = r_sel;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench: a round-robin/packet-lock instance and a fixed-priority instance share one stimulus.
module tb_stream_arb_mux;

    localparam int DW = 16;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din [N];
    logic [N-1:0]  vld;
    logic [N-1:0]  lst;
    logic          rdy;

    logic [N-1:0]  rr_ready, fp_ready;
    logic [DW-1:0] rr_data,  fp_data;
    logic          rr_last,  fp_last;
    logic [1:0]    rr_sel,   fp_sel;
    logic          rr_valid, fp_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_arb_mux #(.DATA_WIDTH(DW), .NUM_INPUT(N), .ARB_MODE(0), .LOCK_ON_LAST(1)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vld), .i_last(lst),
        .o_ready(rr_ready), .o_data(rr_data), .o_last(rr_last), .o_sel(rr_sel),
        .o_valid(rr_valid), .i_ready(rdy)
    );

    stream_arb_mux #(.DATA_WIDTH(DW), .NUM_INPUT(N), .ARB_MODE(1), .LOCK_ON_LAST(0)) u_fp (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vld), .i_last(lst),
        .o_ready(fp_ready), .o_data(fp_data), .o_last(fp_last), .o_sel(fp_sel),
        .o_valid(fp_valid), .i_ready(rdy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        din[0] = 16'h0010; din[1] = 16'h0011; din[2] = 16'h0012;
        rst = 1'b1; vld = 3'b111; lst = 3'b111; rdy = 1'b1;

        // reset with every channel requesting
        tick; tick;
        chk("rst_valid", rr_valid, 0);
        chk("rst_data",  rr_data,  0);
        chk("rst_sel",   rr_sel,   0);
        chk("rst_ready", rr_ready, 0);
        chk("rst_fp_valid", fp_valid, 0);
        chk("rst_fp_ready", fp_ready, 0);

        rst = 1'b0;
        #1;
        chk("rel_ready", rr_ready, 3'b001);

        // round-robin fairness with wrap at channel 2
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("rr_valid", rr_valid, 1);
            chk("rr_sel",   rr_sel,   i % 3);
            chk("rr_data",  rr_data,  16'h0010 + (i % 3));
            chk("fp_sel_all", fp_sel, 0);
        end

        // fixed priority: ch1 always beats ch2
        vld = 3'b110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_ready", fp_ready, 3'b010);
            tick;
            chk("fp_sel",  fp_sel,  1);
            chk("fp_data", fp_data, 16'h0011);
        end

        rst = 1'b1;
        tick;
        rst = 1'b0; vld = 3'b011; lst = 3'b000;

        // packet lock on ch0 with a valid gap mid-packet
        #1; chk("lk_ready0", rr_ready, 3'b001);
        tick; chk("lk_sel0", rr_sel, 0); chk("lk_data0", rr_data, 16'h0010);
        #1; chk("lk_ready1", rr_ready, 3'b001);
        tick; chk("lk_sel1", rr_sel, 0);
        vld = 3'b010;
        #1; chk("lk_gap_ready", rr_ready, 3'b000);
        tick; chk("lk_gap_valid", rr_valid, 0);
        vld = 3'b011; lst = 3'b001;
        #1; chk("lk_ready2", rr_ready, 3'b001);
        tick; chk("lk_sel2", rr_sel, 0); chk("lk_last2", rr_last, 1);
        lst = 3'b010;
        #1; chk("lk_switch_ready", rr_ready, 3'b010);
        tick; chk("lk_switch_sel", rr_sel, 1); chk("lk_switch_data", rr_data, 16'h0011);

        // backpressure holding 0xABCD
        din[2] = 16'hABCD; vld = 3'b100; lst = 3'b100;
        #1; chk("bp_load_ready", rr_ready, 3'b100);
        tick; chk("bp_data", rr_data, 16'hABCD);
        rdy = 1'b0; vld = 3'b011; lst = 3'b000;
        for (int i = 0; i < 4; i++) begin
            #1; chk("bp_ready", rr_ready, 3'b000);
            tick;
            chk("bp_hold_data",  rr_data,  16'hABCD);
            chk("bp_hold_valid", rr_valid, 1);
            chk("bp_hold_sel",   rr_sel,   2);
            chk("bp_hold_last",  rr_last,  1);
        end
        rdy = 1'b1; lst = 3'b111;
        #1; chk("bp_rel_ready", rr_ready, 3'b001);
        tick; chk("bp_next_sel", rr_sel, 0); chk("bp_next_data", rr_data, 16'h0010);

        // reset in the middle of a ch2 packet
        vld = 3'b100; lst = 3'b000;
        #1; chk("mr_ready", rr_ready, 3'b100);
        tick; chk("mr_sel", rr_sel, 2);
        rst = 1'b1; vld = 3'b111;
        #1; chk("mr_rst_ready", rr_ready, 3'b000);
        tick;
        rst = 1'b0; lst = 3'b111;
        #1; chk("mr_valid", rr_valid, 0);
        chk("mr_grant", rr_ready, 3'b001);
        tick; chk("mr_sel_after", rr_sel, 0); chk("mr_data_after", rr_data, 16'h0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised N-to-1 streaming multiplexer with per-channel valid/ready handshakes and built-in arbitration. Replaces the purely combinational index-selected mux wherever several producers share one consumer.
- Selection is internal: round-robin or fixed-priority, with optional packet locking on a last flag.
- Output is registered: 1-cycle latency, full throughput.

Parameters:
- DATA_WIDTH, 16, bit width of each data channel.
- NUM_INPUT, 8, number of input channels (≥1; non-power-of-2 allowed).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- LOCK_ON_LAST, 1, 1 = hold grant until a beat with last=1 is accepted; 0 = re-arbitrate every beat.
- NUM_INPUT_BITWIDTH, derived max(1, $clog2(NUM_INPUT)), width of the channel index.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  DATA_WIDTH x NUM_INPUT (unpacked array)  per-channel data.
- i_valid  in  NUM_INPUT  per-channel valid.
- i_last  in  NUM_INPUT  per-channel end-of-packet flag.
- o_ready  out  NUM_INPUT  per-channel ready; at most one bit set.
- o_data  out  DATA_WIDTH  registered output data.
- o_last  out  1  registered last flag.
- o_sel  out  NUM_INPUT_BITWIDTH  index of the channel that sourced the current output beat.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream ready.

Behaviour:
- Reset (i_rst=1 at an edge): o_valid=0, o_data=0, o_last=0, o_sel=0, RR pointer=0, FSM=ARB. o_ready is combinational: all 0 while i_rst=1.
- Load enable: load = !o_valid || i_ready. The output register may accept a new beat only when load=1.
- Grant logic (combinational):
  - ARB state:
    - request vector = i_valid.
    - ARB_MODE=0: first requester at or after the pointer, circular scan; wrap at NUM_INPUT-1 → 0, not at 2^bits.
    - ARB_MODE=1: lowest-index requester.
  - LOCKED state: only the locked channel may be granted. Other channels get ready=0 even if valid.
- o_ready[k] = load && grant[k]. A transfer on channel k occurs when i_valid[k] && o_ready[k].
- On a transfer: o_data/o_last/o_sel ← channel k values; o_valid←1.
- If load=1 and no transfer: o_valid←0. The data registers hold their old values.
- While o_valid && !i_ready, all outputs stay stable. Required even if the input side changes.
- Latency: input accepted at edge t appears on o_* from edge t until consumed.
- Back-to-back: output consumed and new beat loaded on the same edge. 1 beat/cycle sustained.
- FSM (only when LOCK_ON_LAST=1):
  - ARB → LOCKED on a transfer with i_last=0; lock index = k.
  - LOCKED → ARB on a transfer from the locked channel with i_last=1.
  - In LOCKED, the locked channel deasserting valid causes stall cycles, never a switch.
  - When LOCK_ON_LAST=0 the FSM is tied to ARB and i_last is only forwarded.
- RR pointer update: on a transfer that ends arbitration, pointer ← (k+1) mod NUM_INPUT. "Ends arbitration" means i_last=1, or any beat when LOCK_ON_LAST=0. The pointer is unchanged at mid-packet beats and unused in ARB_MODE=1.
- Reset mid-packet: lock dropped, in-flight output beat discarded (o_valid=0), pointer=0. Upstream must restart its packet.
- NUM_INPUT=1: no arbitration. o_ready[0]=load, o_sel=0.
- No request ever gets X on o_sel. Indices ≥ NUM_INPUT are unreachable by construction.

Decomposition:
- Package stream_mux_pkg:
  - arb_mode_e {ARB_RR=0, ARB_FIXED=1}.
  - fsm state enum {ST_ARB, ST_LOCKED}.
  - function next_idx(idx, n) for modulo-n wrap.
- Sub-module rr_arbiter #(NUM_INPUT, ARB_MODE):
  - inputs: request vector, pointer.
  - outputs: one-hot grant, grant index, any_grant.
  - purely combinational; the top holds the pointer, FSM and output register.

Test Plan:
- Reset: i_rst=1 for 2 cycles with all i_valid=1 → o_valid=0, o_data=0, o_sel=0, o_ready=0. First beat appears 1 cycle after release, o_sel=0.
- RR fairness: NUM_INPUT=3, LOCK_ON_LAST=0, all valid, i_data[k]=k+0x10, i_ready=1 → o_sel sequence 0,1,2,0,1,2, one beat per cycle, o_data 0x10,0x11,0x12…
- Fixed priority: ARB_MODE=1, valid={ch1,ch2} → ch1 always granted, ch2 starved. o_ready[2]=0 throughout.
- Packet lock: ch0 sends 3 beats (last on 3rd) while ch1 valid → o_sel=0 ×3, o_ready[1]=0 during those beats. Then o_sel=1. Inserting a ch0 valid gap mid-packet → stall, no switch.
- Backpressure: i_ready=0 for 4 cycles with o_valid=1, o_data=0xABCD → outputs stable, all o_ready=0. i_ready=1 → 0xABCD consumed, next beat loaded the same edge.
- Reset mid-packet: i_rst pulse after beat 1 of 3 on ch2 → o_valid=0, FSM=ARB, pointer=0. Next grant is the lowest valid channel ≥0.
